// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the max_pool_nd pooling stage.
// Sizes are derived from the instance parameters through the functions below.
package pool_pkg;

    localparam int POOL_DATA_W = 8;
    localparam int POOL_CMP_W  = 64;

    typedef logic signed [POOL_DATA_W-1:0] feature_t;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    function automatic int log2_k(input int k);
        return $clog2(k);
    endfunction

    function automatic int out_dim(input int img, input int k);
        return img / k;
    endfunction

    // A K x K average sum needs 2*log2(K) guard bits above the pixel width.
    function automatic int acc_width(input int data_w, input int k);
        return data_w + 2 * $clog2(k);
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [POOL_CMP_W-1:0] smax(
        input logic signed [POOL_CMP_W-1:0] a,
        input logic signed [POOL_CMP_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the pooler: horizontal accumulator, line buffer and vertical combine.
// MAX_POOL_RELU_EN clamps negative pooled results to zero at the output register.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 2,
    parameter int OW     = 14,
    parameter int IDX_W  = cnt_width(OW)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  pool_mode_e               i_mode,
    input  logic                     i_h_first,
    input  logic                     i_h_last,
    input  logic                     i_v_first,
    input  logic                     i_v_last,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic signed [DATA_W-1:0] i_feature,
    output logic signed [DATA_W-1:0] o_feature
);

    localparam int ACC_W = acc_width(DATA_W, K);
    localparam int SHIFT = 2 * log2_k(K);
    localparam int DEPTH = (OW < 1) ? 1 : OW;

    logic signed [ACC_W-1:0]  h_acc_reg;
    logic signed [ACC_W-1:0]  line_rd_reg;
    logic signed [ACC_W-1:0]  line_buf [DEPTH];
    logic signed [DATA_W-1:0] out_reg;

    logic signed [ACC_W-1:0]  x_ext;
    logic signed [ACC_W-1:0]  h_next;
    logic signed [ACC_W-1:0]  v_next;
    logic signed [ACC_W-1:0]  avg_shift;
    logic signed [DATA_W-1:0] pooled;
    logic signed [DATA_W-1:0] out_next;

    function automatic logic signed [ACC_W-1:0] combine(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b,
        input pool_mode_e              mode
    );
        if (mode == POOL_AVG)
            return a + b;
        return ACC_W'(smax(POOL_CMP_W'(a), POOL_CMP_W'(b)));
    endfunction

    always_comb begin
        x_ext     = ACC_W'(i_feature);
        h_next    = i_h_first ? x_ext : combine(h_acc_reg, x_ext, i_mode);
        v_next    = combine(line_rd_reg, h_next, i_mode);
        // Arithmetic shift gives floor division, so negative averages round down.
        avg_shift = v_next >>> SHIFT;
        pooled    = (i_mode == POOL_AVG) ? avg_shift[DATA_W-1:0] : v_next[DATA_W-1:0];
`ifdef MAX_POOL_RELU_EN
        out_next  = pooled[DATA_W-1] ? '0 : pooled;
`else
        out_next  = pooled;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_acc_reg <= '0;
            out_reg   <= '0;
        end else if (i_en) begin
            h_acc_reg <= h_next;
            if (i_h_last && i_v_last)
                out_reg <= out_next;
        end
    end

    // The stored entry is fetched on the group's first column so the registered
    // read is ready by its last column (K >= 2 guarantees at least one beat between).
    always_ff @(posedge i_clk) begin
        if (i_en && i_h_first)
            line_rd_reg <= line_buf[i_idx];
        if (i_en && i_h_last && !i_v_last)
            line_buf[i_idx] <= i_v_first ? h_next : v_next;
    end

    assign o_feature = out_reg;

endmodule

// File: rtl/max_pool_nd.sv
// K x K stride-K max/average pooling over CHANNELS raster-ordered feature maps.
// Optional fused ReLU on the output is enabled by defining MAX_POOL_RELU_EN.
module max_pool_nd
    import pool_pkg::*;
#(
    parameter int DATA_W   = POOL_DATA_W,
    parameter int CHANNELS = 6,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_avg,
    input  logic                             i_feature_valid,
    input  logic [CHANNELS-1:0][DATA_W-1:0]  i_features,
    output logic                             o_feature_valid,
    output logic [CHANNELS-1:0][DATA_W-1:0]  o_features,
    output logic                             o_frame_done
);

    localparam int LOG2K = log2_k(K);
    localparam int OW    = out_dim(IMG_W, K);
    localparam int OH    = out_dim(IMG_H, K);
    localparam int CW    = cnt_width(IMG_W + 1);
    localparam int RW    = cnt_width(IMG_H + 1);
    localparam int IDX_W = cnt_width(OW);

    if (!(K == 2 || K == 4 || K == 8)) begin : g_bad_k
        $error("max_pool_nd: K must be 2, 4 or 8");
    end
    if (DATA_W < 2) begin : g_bad_w
        $error("max_pool_nd: DATA_W must be at least 2");
    end

    logic [CW-1:0]    col_reg, col_next;
    logic [RW-1:0]    row_reg, row_next;
    pool_mode_e       mode_reg, mode_next;
    logic             valid_reg, valid_next;
    logic             done_reg, done_next;

    logic             first_px;
    pool_mode_e       mode_cur;
    logic [LOG2K-1:0] col_phase;
    logic [LOG2K-1:0] row_phase;
    logic             h_first, h_last, v_first, v_last;
    logic             last_col, last_row;
    logic             active;
    logic [IDX_W-1:0] win_idx;
    logic [CHANNELS-1:0][DATA_W-1:0] lane_out;

    always_comb begin
        first_px  = (col_reg == '0) && (row_reg == '0);
        // The mode beat itself must already pool in the newly sampled mode.
        mode_cur  = first_px ? pool_mode_e'(i_avg) : mode_reg;
        col_phase = LOG2K'(col_reg);
        row_phase = LOG2K'(row_reg);
        h_first   = (col_phase == '0);
        h_last    = (col_phase == LOG2K'(K - 1));
        v_first   = (row_phase == '0);
        v_last    = (row_phase == LOG2K'(K - 1));
        last_col  = (col_reg == CW'(IMG_W - 1));
        last_row  = (row_reg == RW'(IMG_H - 1));
        active    = i_feature_valid
                  && (col_reg < CW'(OW * K))
                  && (row_reg < RW'(OH * K));
        win_idx   = IDX_W'(col_reg >> LOG2K);
    end

    always_comb begin
        col_next   = col_reg;
        row_next   = row_reg;
        mode_next  = mode_reg;
        valid_next = active && h_last && v_last;
        done_next  = i_feature_valid && last_col && last_row;
        if (i_feature_valid) begin
            if (first_px)
                mode_next = mode_cur;
            if (last_col) begin
                col_next = '0;
                row_next = last_row ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_reg   <= '0;
            row_reg   <= '0;
            mode_reg  <= POOL_MAX;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            col_reg   <= col_next;
            row_reg   <= row_next;
            mode_reg  <= mode_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        pool_lane #(
            .DATA_W (DATA_W),
            .K      (K),
            .OW     (OW),
            .IDX_W  (IDX_W)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_en      (active),
            .i_mode    (mode_cur),
            .i_h_first (h_first),
            .i_h_last  (h_last),
            .i_v_first (v_first),
            .i_v_last  (v_last),
            .i_idx     (win_idx),
            .i_feature (i_features[gi]),
            .o_feature (lane_out[gi])
        );
    end

    assign o_feature_valid = valid_reg;
    assign o_features      = lane_out;
    assign o_frame_done    = done_reg;

endmodule

// File: tb/tb_max_pool_nd.sv
// Scoreboard bench for max_pool_nd: a 4x4 instance and a 5x5 instance, K=2, two channels.
// Expected windows are computed from a stored copy of each frame.
module tb_max_pool_nd;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int K  = 2;

    typedef struct {
        int                   due;
        logic [CH-1:0][DW-1:0] v;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            in_valid;
    logic [1:0]            in_avg;
    logic [CH-1:0][DW-1:0] in_feat  [2];
    logic [1:0]            out_valid;
    logic [1:0]            out_done;
    logic [CH-1:0][DW-1:0] out_feat [2];

    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    exp_t exp_q  [2][$];
    int   done_q [2][$];

    int   pr [2];
    int   pc [2];
    bit   mavg [2];
    int   pix [2][CH][5][5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 4 : 5;
        max_pool_nd #(
            .DATA_W   (DW),
            .CHANNELS (CH),
            .IMG_W    (W),
            .IMG_H    (W),
            .K        (K)
        ) u_dut (
            .i_clk           (clk),
            .i_rst_n         (rst_n),
            .i_avg           (in_avg[gi]),
            .i_feature_valid (in_valid[gi]),
            .i_features      (in_feat[gi]),
            .o_feature_valid (out_valid[gi]),
            .o_features      (out_feat[gi]),
            .o_frame_done    (out_done[gi])
        );
    end

    function automatic int dim(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            pr[d] = 0;
            pc[d] = 0;
            mavg[d] = 1'b0;
            exp_q[d].delete();
            done_q[d].delete();
        end
    endfunction

    // Reference: remember every pixel, and when a beat completes a full window
    // evaluate that window directly from the stored frame.
    function automatic void model_accept(input int d, input logic [CH-1:0][DW-1:0] px, input logic avg);
        int   w;
        int   lim;
        int   res;
        int   s;
        exp_t e;
        w = dim(d);
        lim = (w / K) * K;
        if (pr[d] == 0 && pc[d] == 0)
            mavg[d] = avg;
        for (int ch = 0; ch < CH; ch++)
            pix[d][ch][pr[d]][pc[d]] = int'(signed'(px[ch]));
        if ((pr[d] % K == K - 1) && (pc[d] % K == K - 1) && pr[d] < lim && pc[d] < lim) begin
            e.due = cyc + 1;
            for (int ch = 0; ch < CH; ch++) begin
                s = 0;
                res = -100000;
                for (int r = pr[d] - K + 1; r <= pr[d]; r++)
                    for (int c = pc[d] - K + 1; c <= pc[d]; c++) begin
                        s = s + pix[d][ch][r][c];
                        if (pix[d][ch][r][c] > res)
                            res = pix[d][ch][r][c];
                    end
                if (mavg[d]) begin
                    res = s / (K * K);
                    if (s < 0 && (s % (K * K)) != 0)
                        res = res - 1;
                end
`ifdef MAX_POOL_RELU_EN
                if (res < 0)
                    res = 0;
`endif
                e.v[ch] = res[DW-1:0];
            end
            exp_q[d].push_back(e);
        end
        if (pr[d] == w - 1 && pc[d] == w - 1)
            done_q[d].push_back(cyc + 1);
        if (pc[d] == w - 1) begin
            pc[d] = 0;
            pr[d] = (pr[d] == w - 1) ? 0 : pr[d] + 1;
        end else begin
            pc[d] = pc[d] + 1;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else begin
            $display("check %s = %h ok", name, got);
        end
    endtask

    task automatic beat(input int d, input logic [CH-1:0][DW-1:0] px, input logic avg);
        @(negedge clk);
        in_valid    = '0;
        in_valid[d] = 1'b1;
        in_feat[d]  = px;
        in_avg[d]   = avg;
        model_accept(d, px, avg);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = '0;
        end
    endtask

    // kind 0: ramp, 1: -128 with one -1 per window, 2: avg windows, 3: random
    task automatic send_frame(input int d, input int kind, input int gapmax, input logic avg,
                              input bit toggle, input int npix);
        int w;
        int r;
        int c;
        int win;
        int pos;
        int v;
        logic [CH-1:0][DW-1:0] px;
        logic a;
        w = dim(d);
        for (int i = 0; i < npix; i++) begin
            r = i / w;
            c = i % w;
            win = (r / 2) * 2 + (c / 2);
            pos = (r % 2) * 2 + (c % 2);
            for (int ch = 0; ch < CH; ch++) begin
                v = int'($urandom_range(0, 255)) - 128;
                case (kind)
                    0: if (ch == 0) v = i;
                    1: v = (pos == (win + ch) % 4) ? -1 : -128;
                    2: if (ch == 0 && r < 2) v = (c < 2) ? pos + 1 : -(pos + 1);
                    default: ;
                endcase
                px[ch] = v[DW-1:0];
            end
            a = (toggle && i > 0) ? 1'($urandom_range(0, 1)) : avg;
            beat(d, px, a);
            if (gapmax > 0)
                idle(int'($urandom_range(0, gapmax)));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d]) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        fails++;
                        $display("FAIL spurious_valid dut%0d cyc=%0d got=%h required=no output", d, cyc, out_feat[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        if (e.due != cyc || out_feat[d] !== e.v) begin
                            fails++;
                            $display("FAIL pooled dut%0d got=%h at cyc %0d required=%h at cyc %0d",
                                     d, out_feat[d], cyc, e.v, e.due);
                        end else begin
                            $display("dut%0d cyc=%0d pooled=%h ok", d, cyc, out_feat[d]);
                        end
                    end
                end
                while (exp_q[d].size() > 0 && exp_q[d][0].due < cyc) begin
                    e = exp_q[d].pop_front();
                    checks++;
                    fails++;
                    $display("FAIL missing_valid dut%0d got=none required=%h at cyc %0d", d, e.v, e.due);
                end
                if (out_done[d]) begin
                    checks++;
                    if (done_q[d].size() == 0 || done_q[d][0] != cyc) begin
                        fails++;
                        $display("FAIL frame_done dut%0d got=pulse at cyc %0d required=none", d, cyc);
                    end else begin
                        dc = done_q[d].pop_front();
                        $display("dut%0d cyc=%0d frame_done ok", d, dc);
                    end
                end
                while (done_q[d].size() > 0 && done_q[d][0] < cyc) begin
                    dc = done_q[d].pop_front();
                    checks++;
                    fails++;
                    $display("FAIL frame_done dut%0d got=none required=pulse at cyc %0d", d, dc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid   = '0;
        in_avg     = '0;
        in_feat[0] = '0;
        in_feat[1] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_valid%0d", d), 64'(out_valid[d]), 64'd0);
            chk($sformatf("reset_done%0d", d), 64'(out_done[d]), 64'd0);
            chk($sformatf("reset_feat%0d", d), 64'(out_feat[d]), 64'd0);
        end
        rst_n = 1'b1;

        send_frame(0, 0, 0, 1'b0, 1'b0, 16);   // ramp, max
        send_frame(0, 1, 0, 1'b0, 1'b0, 16);   // signed max
        send_frame(0, 2, 0, 1'b1, 1'b1, 16);   // avg, mode toggled mid-frame
        send_frame(0, 0, 5, 1'b0, 1'b0, 16);   // ramp with valid gaps
        for (int f = 0; f < 3; f++)
            send_frame(0, 3, 0, 1'($urandom_range(0, 1)), 1'b1, 16);
        send_frame(0, 3, 3, 1'b1, 1'b0, 16);
        idle(3);

        // Reset mid-frame after 6 pixels; the pixel-5 window output is checked first.
        send_frame(0, 0, 0, 1'b0, 1'b0, 6);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(out_valid[0]), 64'd0);
        chk("midreset_done", 64'(out_done[0]), 64'd0);
        chk("midreset_feat", 64'(out_feat[0]), 64'd0);
        model_reset();
        @(negedge clk);
        chk("midreset_hold_feat", 64'(out_feat[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(0, 0, 0, 1'b0, 1'b0, 16);
        idle(3);

        // 5x5: trailing row/column ignored, back-to-back frames.
        send_frame(1, 0, 0, 1'b0, 1'b0, 25);
        send_frame(1, 0, 0, 1'b0, 1'b0, 25);
        send_frame(1, 3, 0, 1'b1, 1'b0, 25);
        send_frame(1, 3, 2, 1'b0, 1'b1, 25);
        idle(4);

        for (int d = 0; d < 2; d++)
            chk($sformatf("drained%0d", d), 64'(exp_q[d].size() + done_q[d].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
